// File: rtl/barrel_shifter_8_if.sv
// Operand/result bundle for the registered barrel shifter.
// The master drives operands; the slave returns the registered result.
interface barrel_shifter_8_if #(
  parameter int WIDTH = 8,
  parameter int SHW   = 4
);
  logic             in_valid;
  logic [WIDTH-1:0] num;
  logic [SHW-1:0]   shift;
  logic [1:0]       op;
  logic [WIDTH-1:0] ans;
  logic             out_valid;

  modport master (
    output in_valid,
    output num,
    output shift,
    output op,
    input  ans,
    input  out_valid
  );

  modport slave (
    input  in_valid,
    input  num,
    input  shift,
    input  op,
    output ans,
    output out_valid
  );
endinterface

// File: rtl/barrel_shifter_8.sv
// Registered barrel shifter/rotator: SLL, SRL, SRA, ROL.
// log2(WIDTH) mux stages plus an overflow stage, one-cycle latency.
module barrel_shifter_8 #(
  parameter int WIDTH = 8,
  parameter int SHW   = 4
) (
  input logic               clk,
  input logic               rst,
  barrel_shifter_8_if.slave bus
);

  localparam int LW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROL = 2'b11
  } op_e;

  op_e              w_op;
  logic             w_ovf;
  logic [WIDTH-1:0] w_stg;
  logic [WIDTH-1:0] w_res;
  logic [WIDTH-1:0] r_ans;
  logic             r_valid;

  assign w_op = op_e'(bus.op);

  function automatic logic [WIDTH-1:0] stage(
    input logic [WIDTH-1:0] v,
    input int               amt,
    input op_e              o
  );
    logic [WIDTH-1:0] r;
    r = v;
    unique case (o)
      OP_SLL: r = v << amt;
      OP_SRL: r = v >> amt;
      OP_SRA: r = $signed(v) >>> amt;
      OP_ROL: r = (v << amt) | (v >> (WIDTH - amt));
      default: r = v;
    endcase
    return r;
  endfunction

  always_comb begin
    w_stg = bus.num;
    for (int k = 0; k < LW; k++) begin
      if (bus.shift[k]) w_stg = stage(w_stg, 1 << k, w_op);
    end
  end

  // Amounts >= WIDTH saturate shifts; rotates only use shift mod WIDTH.
  if (SHW > LW) begin : g_ovf
    assign w_ovf = |bus.shift[SHW-1:LW];
  end else begin : g_no_ovf
    assign w_ovf = 1'b0;
  end

  always_comb begin
    w_res = w_stg;
    if (w_ovf) begin
      unique case (w_op)
        OP_SLL: w_res = '0;
        OP_SRL: w_res = '0;
        OP_SRA: w_res = {WIDTH{bus.num[WIDTH-1]}};
        OP_ROL: w_res = w_stg;
        default: w_res = w_stg;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ans   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= bus.in_valid;
      if (bus.in_valid) r_ans <= w_res;
    end
  end

  assign bus.ans       = r_ans;
  assign bus.out_valid = r_valid;

endmodule

// File: tb/tb_barrel_shifter_8.sv
// Bench for barrel_shifter_8: vector table, corner sequences,
// exhaustive sweep against a bit-level reference model.
module tb_barrel_shifter_8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  barrel_shifter_8_if bus ();

  barrel_shifter_8 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] num;
    logic [3:0] shift;
    logic [1:0] op;
    logic [7:0] exp;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] sb[$];
  logic [7:0] last_ans;
  vec_t       vt[$];

  function automatic logic [7:0] model(
    input logic [7:0] n,
    input logic [3:0] s,
    input logic [1:0] o
  );
    logic [7:0] r;
    int         src;
    for (int i = 0; i < 8; i++) begin
      case (o)
        2'b00: begin
          src  = i - int'(s);
          r[i] = (src >= 0) ? n[src] : 1'b0;
        end
        2'b01: begin
          src  = i + int'(s);
          r[i] = (src < 8) ? n[src] : 1'b0;
        end
        2'b10: begin
          src  = i + int'(s);
          r[i] = (src < 8) ? n[src] : n[7];
        end
        default: begin
          src  = (i - (int'(s) % 8) + 8) % 8;
          r[i] = n[src];
        end
      endcase
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] n,
                       input logic [3:0] s, input logic [1:0] o,
                       input logic [7:0] exp, input string nm);
    logic [7:0] e;
    bus.in_valid = v;
    bus.num      = n;
    bus.shift    = s;
    bus.op       = o;
    if (v) sb.push_back(exp);
    @(posedge clk);
    #1;
    chk({nm, ".valid"}, {7'b0, bus.out_valid}, {7'b0, v});
    if (v) begin
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL %s: scoreboard empty", nm);
      end else begin
        e = sb.pop_front();
        chk(nm, bus.ans, e);
        last_ans = e;
      end
    end else begin
      chk({nm, ".hold"}, bus.ans, last_ans);
    end
  endtask

  initial begin
    bus.in_valid = 1'b1;
    bus.num      = 8'hAA;
    bus.shift    = 4'd5;
    bus.op       = 2'b00;
    last_ans     = 8'h00;

    vt.push_back('{8'hAA, 4'd5, 2'b00, 8'h40});
    vt.push_back('{8'hAA, 4'd5, 2'b01, 8'h05});
    vt.push_back('{8'hAA, 4'd5, 2'b10, 8'hFD});
    vt.push_back('{8'hAA, 4'd5, 2'b11, 8'h55});
    vt.push_back('{8'hAA, 4'd9, 2'b00, 8'h00});
    vt.push_back('{8'hAA, 4'd9, 2'b01, 8'h00});
    vt.push_back('{8'hAA, 4'd9, 2'b10, 8'hFF});
    vt.push_back('{8'hAA, 4'd9, 2'b11, 8'h55});
    vt.push_back('{8'h81, 4'd1, 2'b11, 8'h03});
    vt.push_back('{8'h81, 4'd8, 2'b11, 8'h81});
    vt.push_back('{8'h81, 4'd0, 2'b11, 8'h81});
    vt.push_back('{8'hAA, 4'd0, 2'b10, 8'hAA});
    vt.push_back('{8'h80, 4'd15, 2'b10, 8'hFF});
    vt.push_back('{8'h7F, 4'd15, 2'b10, 8'h00});
    vt.push_back('{8'h7F, 4'd8, 2'b10, 8'h00});
    vt.push_back('{8'h01, 4'd7, 2'b00, 8'h80});
    vt.push_back('{8'h80, 4'd7, 2'b01, 8'h01});
    vt.push_back('{8'hC3, 4'd4, 2'b11, 8'h3C});
    vt.push_back('{8'h5A, 4'd8, 2'b00, 8'h00});

    // reset held with in_valid high, before and across a clock edge
    #1;
    chk("rst.ans", bus.ans, 8'h00);
    chk("rst.valid", {7'b0, bus.out_valid}, 8'h00);
    @(posedge clk);
    #1;
    chk("rst_edge.ans", bus.ans, 8'h00);
    chk("rst_edge.valid", {7'b0, bus.out_valid}, 8'h00);
    rst = 1'b0;

    drive(1'b0, 8'h00, 4'd0, 2'b00, 8'h00, "idle");

    foreach (vt[i])
      drive(1'b1, vt[i].num, vt[i].shift, vt[i].op, vt[i].exp,
            $sformatf("vec%0d", i));

    drive(1'b0, 8'hFF, 4'd3, 2'b01, 8'h00, "gap");
    drive(1'b0, 8'h0F, 4'd1, 2'b00, 8'h00, "gap2");

    // async reset mid-cycle discards pending op
    drive(1'b1, 8'h81, 4'd1, 2'b11, 8'h03, "pre_rst");
    bus.in_valid = 1'b1;
    bus.num      = 8'hFF;
    bus.shift    = 4'd0;
    bus.op       = 2'b00;
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst.ans", bus.ans, 8'h00);
    chk("async_rst.valid", {7'b0, bus.out_valid}, 8'h00);
    @(posedge clk);
    #1;
    chk("rst_hold.valid", {7'b0, bus.out_valid}, 8'h00);
    rst = 1'b0;
    sb.delete();
    last_ans = 8'h00;
    drive(1'b0, 8'h12, 4'd2, 2'b00, 8'h00, "post_rst_idle");
    drive(1'b1, 8'h12, 4'd2, 2'b00, 8'h48, "post_rst_first");

    for (int o = 0; o < 4; o++)
      for (int s = 0; s < 16; s++)
        for (int n = 0; n < 256; n++)
          drive(1'b1, n[7:0], s[3:0], o[1:0],
                model(n[7:0], s[3:0], o[1:0]),
                $sformatf("ex_o%0d_s%0d_n%0d", o, s, n));

    drive(1'b0, 8'h00, 4'd0, 2'b00, 8'h00, "tail");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
